// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, fetch FSM states, instruction field positions, fetch FIFO entry.
// Latency: none, this package holds declarations only.
// Backpressure: not applicable.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {instr, pc} entries, with flush.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; the caller's credit scheme keeps push off a full FIFO.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push_vld,
    input  fetch_entry_t  i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output fetch_entry_t  o_head_dat
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(i_push_vld) - CW'(i_pop);
        end
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests imem words, buffers them (FETCH_MISALIGN_CHECK_EN adds halt on misaligned redirect).
// Latency: response in cycle N is presented to the controller in cycle N+1.
// Backpressure: requests stop when in-flight plus buffered words reach FIFO_DEPTH; instr held until instr_ready.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        fetch_fault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_pcq [FIFO_DEPTH];
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_credit_used;
    logic [CW-1:0] w_inflight_nxt;
    logic          w_req_fire;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_misalign;
    logic [31:0]   w_redir_pc;
    fetch_entry_t  w_push_dat;
    fetch_entry_t  w_head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;
    assign w_redir_pc  = redirect_pc;
    assign w_misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = r_fault;
`else
    assign w_redir_pc  = redirect_pc & ~32'h3;
    assign w_misalign  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign instr_valid = (r_state == S_RUN) && (w_count != '0);
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;

    // A pop frees its slot at this edge, so it returns credit at once to sustain one word per cycle.
    assign w_credit_used  = r_inflight + w_count - CW'(w_pop);
    assign imem_req_valid = (r_state == S_RUN) && !redirect_valid
                            && (w_credit_used < CW'(FIFO_DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop     = imem_rsp_valid && (r_discard != '0);
    assign w_push         = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
    assign w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
    assign w_push_dat     = '{instr: imem_rsp_data, pc: r_pcq[r_pcq_rd]};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push_vld (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_count    (w_count),
        .o_head_dat (w_head)
    );

    assign instr    = instr_valid ? w_head.instr : '0;
    assign instr_pc = instr_valid ? w_head.pc    : '0;
    assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct3   = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7   = instr[FUNCT7_MSB:FUNCT7_LSB];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            r_inflight <= w_inflight_nxt;
            // Everything still outstanding after a redirect belongs to the old path.
            if (redirect_valid) begin
                r_discard <= w_inflight_nxt;
            end else if (w_rsp_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_req_fire) begin
                r_pcq[r_pcq_wr] <= r_fetch_pc;
                r_pcq_wr        <= r_pcq_wr + PW'(1);
            end
            if (imem_rsp_valid) begin
                r_pcq_rd <= r_pcq_rd + PW'(1);
            end
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            case (r_state)
                S_BOOT:  r_state <= S_RUN;
                S_RUN:   if (w_misalign) r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (w_misalign && (r_state == S_RUN)) begin
                r_fault <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory model.
// A second instance with RESET_PC near the top of memory shares all inputs to observe PC wrap.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        imem_req_valid, instr_valid, fetch_fault;
    logic [31:0] imem_req_addr, instr, instr_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    logic        hi_imem_req_valid, hi_instr_valid, hi_fetch_fault;
    logic [31:0] hi_imem_req_addr, hi_instr, hi_instr_pc;
    logic [6:0]  hi_opcode, hi_funct7;
    logic [2:0]  hi_funct3;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc, lat, mem_mode, n_req, n_got, n_hi, n_chk, n_err;
    logic [31:0] got_pc  [32];
    logic [31:0] got_ins [32];
    logic [31:0] got_hi  [32];

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .fetch_fault(fetch_fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_hi (
        .clock(clock), .reset(reset),
        .imem_req_valid(hi_imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(hi_imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(hi_instr_valid), .instr_ready(instr_ready), .instr(hi_instr), .instr_pc(hi_instr_pc),
        .opcode(hi_opcode), .funct3(hi_funct3), .funct7(hi_funct7), .fetch_fault(hi_fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_mode == 0) return 32'h0000_0013;
        if (a == 32'h0000_0200) return 32'h4020_D0B3;
        return a ^ K;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            mq.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic sample();
        mreq_t m;
        @(negedge clock);
        if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            n_req++;
        end
        if (instr_valid && instr_ready && !redirect_valid && n_got < 32) begin
            got_pc[n_got]  = instr_pc;
            got_ins[n_got] = instr;
            n_got++;
        end
        if (hi_instr_valid && instr_ready && !redirect_valid && n_hi < 32) begin
            got_hi[n_hi] = hi_instr_pc;
            n_hi++;
        end
    endtask

    task automatic step();
        advance();
        sample();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        cyc   = 0;
        n_req = 0;
        n_got = 0;
        n_hi  = 0;
        for (int i = 0; i < 32; i++) begin
            got_pc[i]  = 32'hDEAD_BEEF;
            got_ins[i] = 32'hDEAD_BEEF;
            got_hi[i]  = 32'hDEAD_BEEF;
        end
        sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        lat = 1; mem_mode = 0;
        reset = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Reset values, first-valid latency, zero-wait streaming, PC wrap
        do_reset();
        chk("rst_req_vld", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_hi_req_addr", hi_imem_req_addr, 32'hFFFF_FFF8);
        chk("rst_instr_vld", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fields", {opcode, funct3, funct7}, 32'h0);
        chk("rst_fault", fetch_fault, 1'b0);
        step();
        chk("c1_req_vld", imem_req_valid, 1'b1);
        chk("c1_req_addr", imem_req_addr, 32'h0);
        step();
        chk("c2_instr_vld", instr_valid, 1'b0);
        step();
        chk("c3_instr_vld", instr_valid, 1'b1);
        chk("c3_instr", instr, 32'h0000_0013);
        chk("c3_opcode", opcode, 7'h13);
        repeat (3) step();
        for (int i = 0; i < 4; i++) chk($sformatf("seq_pc%0d", i), got_pc[i], 32'(4 * i));
        chk("seq_count", n_got, 4);
        chk("wrap_pc0", got_hi[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", got_hi[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", got_hi[2], 32'h0000_0000);
        chk("wrap_pc3", got_hi[3], 32'h0000_0004);

        // Consumer stall: credit limits requests, release delivers in order
        mem_mode = 1;
        instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("bp_req_count", n_req, 2);
        chk("bp_req_vld", imem_req_valid, 1'b0);
        chk("bp_instr_vld", instr_valid, 1'b1);
        chk("bp_no_pop", n_got, 0);
        advance();
        instr_ready = 1'b1;
        sample();
        repeat (7) step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_pc%0d", i), got_pc[i], 32'(4 * i));
            chk($sformatf("bp_ins%0d", i), got_ins[i], 32'(4 * i) ^ K);
        end

        // 3-cycle memory, redirect with two stale responses outstanding
        lat = 3;
        do_reset();
        step();
        step();
        advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        sample();
        chk("rd_req_suppr", imem_req_valid, 1'b0);
        step();
        chk("rd_c4_vld", instr_valid, 1'b0);
        chk("rd_c4_req", imem_req_valid, 1'b0);
        step();
        chk("rd_c5_req", imem_req_valid, 1'b1);
        chk("rd_c5_addr", imem_req_addr, 32'h0000_0100);
        repeat (5) step();
        chk("rd_count", n_got, 2);
        chk("rd_pc0", got_pc[0], 32'h0000_0100);
        chk("rd_ins0", got_ins[0], 32'h0000_0100 ^ K);
        chk("rd_pc1", got_pc[1], 32'h0000_0104);

        // Redirect coinciding with a response and a pop
        lat = 1;
        do_reset();
        repeat (4) step();
        advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        sample();
        chk("rc_rsp_present", imem_rsp_valid, 1'b1);
        chk("rc_req_suppr", imem_req_valid, 1'b0);
        step();
        chk("rc_c6_vld", instr_valid, 1'b0);
        chk("rc_c6_req", imem_req_valid, 1'b1);
        chk("rc_c6_addr", imem_req_addr, 32'h0000_0200);
        step();
        chk("rc_delivered", n_got, 2);
        step();
        chk("rc_pc", instr_pc, 32'h0000_0200);
        chk("rc_instr", instr, 32'h4020_D0B3);
        chk("rc_opcode", opcode, 7'h33);
        chk("rc_funct3", funct3, 3'h5);
        chk("rc_funct7", funct7, 7'h20);

        // Misaligned redirect
        n_req = 0;
        advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        sample();
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault", fetch_fault, 1'b1);
        chk("mis_req", imem_req_valid, 1'b0);
        repeat (5) step();
        chk("halt_reqs", n_req, 0);
        chk("halt_vld", instr_valid, 1'b0);
        chk("halt_fault", fetch_fault, 1'b1);
`else
        chk("mis_fault", fetch_fault, 1'b0);
        chk("mis_req", imem_req_valid, 1'b1);
        chk("mis_addr", imem_req_addr, 32'h0000_0100);
        step();
        step();
        chk("mis_vld", instr_valid, 1'b1);
        chk("mis_pc", instr_pc, 32'h0000_0100);
`endif

        // Reset from mid-operation returns to boot
        do_reset();
        chk("final_fault", fetch_fault, 1'b0);
        chk("final_addr", imem_req_addr, 32'h0);
        step();
        chk("final_req", imem_req_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
